ofd5_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one 5-bit registered output port (five output flip-flops on the same CK) among NREQ requesters.
- The winning requester's word is driven onto D[4:0], which feeds the output-flop inputs, for HOLD cycles. An optional idle gap of GAP cycles follows, during which D carries IDLE_VAL.
- Sits directly in front of the output register bank. It is the only driver of that bank's D inputs.

---
 rtl/ofd5_arb.sv | 181 ++++++++++++++++++
 tb/tb_ofd5_arb.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ofd5_arb.sv
// ---------------------------------------------------------------------------
// ofd5_arb
//
// Round-robin arbiter and sequencer for a shared 5-bit registered output
// port. Several requesters compete for the port. The winner's word is placed
// on D for HOLD cycles. An optional gap of GAP cycles at IDLE_VAL follows.
// The block is the only driver of the output flop bank's D inputs.
//
// Ports
//   CK        in   1         clock, rising edge
//   RN        in   1         asynchronous active-low reset
//   REQ       in   NREQ      per-requester request level
//   DIN       in   5*NREQ    requester i word on bits [5i+4:5i]
//   ACK       out  NREQ      one-hot, one-cycle pulse on the grant edge
//   D         out  5         word presented to the output flop bank
//   OWNER     out  clog2     index of the current owner (valid while BUSY)
//   BUSY      out  1         high while a granted word is on D
//   DBG_STATE out  2         current sequencer state (IDLE/DRIVE/GAP)
//
// Handshake: a requester raises REQ and holds REQ and its DIN word stable
// until it sees its ACK bit. DIN is sampled only on the grant edge, which is
// the same edge that raises ACK. REQ is a level: if it is still high at the
// next arbitration point, it counts as a fresh request. Dropping REQ before
// the grant withdraws it cleanly. Dropping REQ during DRIVE does not shorten
// the hold time.
//
// All outputs come straight from flops, so there is no combinational path
// from REQ or DIN to D or ACK.
// ---------------------------------------------------------------------------
module ofd5_arb #(
    parameter int          NREQ     = 4,
    parameter int          HOLD     = 2,
    parameter int          GAP      = 1,
    parameter logic [4:0]  IDLE_VAL = 5'b00000,
    localparam int         OW       = $clog2(NREQ)
) (
    input  logic                CK,
    input  logic                RN,
    input  logic [NREQ-1:0]     REQ,
    input  logic [5*NREQ-1:0]   DIN,
    output logic [NREQ-1:0]     ACK,
    output logic [4:0]          D,
    output logic [OW-1:0]       OWNER,
    output logic                BUSY,
    output logic [1:0]          DBG_STATE
);

    // The counter only ever holds HOLD-1 or GAP-1, so it is sized for the
    // larger of the two.
    localparam int MAXC = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [OW-1:0]      ptr_q,   ptr_d;
    logic [CW-1:0]      cnt_q,   cnt_d;
    logic [4:0]         d_q,     d_d;
    logic [NREQ-1:0]    ack_q,   ack_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic               busy_q,  busy_d;

    logic               win_found;
    logic [OW-1:0]      win_idx;
    logic               arb_point;

    // -----------------------------------------------------------------------
    // Rotating priority search: the first set REQ bit at or above ptr_q,
    // wrapping modulo NREQ. The found flag stops later candidates from
    // overriding the first hit.
    // -----------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && REQ[(int'(ptr_q) + k) % NREQ]) begin
                win_found = 1'b1;
                win_idx   = OW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    // An arbitration point is IDLE, the final GAP cycle, or the final DRIVE
    // cycle when there is no gap. The last case is what allows back-to-back
    // words without an IDLE_VAL cycle between them.
    always_comb begin
        arb_point = 1'b0;
        case (state_q)
            S_IDLE:  arb_point = 1'b1;
            S_DRIVE: arb_point = (cnt_q == '0) && (GAP == 0);
            S_GAP:   arb_point = (cnt_q == '0);
            default: arb_point = 1'b1;
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state and registered-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        ack_d   = '0;          // ACK is a single-cycle pulse by default
        owner_d = owner_q;
        busy_d  = busy_q;

        if (arb_point) begin
            if (win_found) begin
                state_d = S_DRIVE;
                d_d     = DIN[5*win_idx +: 5];
                ack_d   = NREQ'(1) << win_idx;
                owner_d = win_idx;
                busy_d  = 1'b1;
                cnt_d   = CW'(HOLD - 1);
                ptr_d   = OW'((int'(win_idx) + 1) % NREQ);
            end else begin
                state_d = S_IDLE;
                d_d     = IDLE_VAL;
                busy_d  = 1'b0;
            end
        end else begin
            case (state_q)
                S_DRIVE: begin
                    if (cnt_q == '0) begin
                        // This branch is only reached when GAP > 0, because
                        // with GAP == 0 the last DRIVE cycle is an
                        // arbitration point.
                        state_d = S_GAP;
                        d_d     = IDLE_VAL;
                        busy_d  = 1'b0;
                        cnt_d   = CW'(GAP - 1);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_GAP: begin
                    cnt_d = cnt_q - 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                    d_d     = IDLE_VAL;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // Reset abandons any word in progress. No ACK is issued for it, and
    // arbitration restarts from requester 0.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            d_q     <= IDLE_VAL;
            ack_q   <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            ack_q   <= ack_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
        end
    end

    assign D         = d_q;
    assign ACK       = ack_q;
    assign OWNER     = owner_q;
    assign BUSY      = busy_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_ofd5_arb.sv
module tb_ofd5_arb;

  // clock / reset
  logic        CK = 1'b0;
  logic        RN = 1'b0;
  always #5 CK = ~CK;

  // default build: NREQ=4 HOLD=2 GAP=1
  logic [3:0]  req  = '0;
  logic [19:0] din  = '0;
  logic [3:0]  ack;
  logic [4:0]  d;
  logic [1:0]  owner;
  logic        busy;
  logic [1:0]  dbg;

  // back-to-back build: HOLD=1 GAP=0
  logic [3:0]  req1 = '0;
  logic [19:0] din1 = '0;
  logic [3:0]  ack1;
  logic [4:0]  d1;
  logic [1:0]  owner1;
  logic        busy1;
  logic [1:0]  dbg1;

  int n_checks = 0;
  int n_errors = 0;

  ofd5_arb #(.NREQ(4), .HOLD(2), .GAP(1), .IDLE_VAL(5'b00000)) u_dut (
    .CK(CK), .RN(RN), .REQ(req), .DIN(din),
    .ACK(ack), .D(d), .OWNER(owner), .BUSY(busy), .DBG_STATE(dbg)
  );

  ofd5_arb #(.NREQ(4), .HOLD(1), .GAP(0), .IDLE_VAL(5'b00000)) u_b2b (
    .CK(CK), .RN(RN), .REQ(req1), .DIN(din1),
    .ACK(ack1), .D(d1), .OWNER(owner1), .BUSY(busy1), .DBG_STATE(dbg1)
  );

  // driver tasks
  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // hand-computed contention sequence, REQ=1111, words 1,2,3,4
  logic [4:0] cont_d   [13] = '{5'd1, 5'd1, 5'd0, 5'd2, 5'd2, 5'd0, 5'd3, 5'd3, 5'd0,
                                5'd4, 5'd4, 5'd0, 5'd1};
  logic [3:0] cont_ack [13] = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000,
                                4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000,
                                4'b0001};
  logic       cont_bsy [13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                                1'b1, 1'b1, 1'b0, 1'b1};
  logic [1:0] cont_own [13] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                                2'd3, 2'd3, 2'd3, 2'd0};

  initial begin
    // ---- reset with all requests high
    req = 4'b1111;
    din[0 +: 5]  = 5'd1;
    din[5 +: 5]  = 5'd2;
    din[10 +: 5] = 5'd3;
    din[15 +: 5] = 5'd4;
    #2;
    chk("rst_d",     32'(d),     32'h00);
    chk("rst_ack",   32'(ack),   32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    tick();
    tick();
    chk("rst_d_clk",    32'(d),    32'h00);
    chk("rst_ack_clk",  32'(ack),  32'h0);
    chk("rst_busy_clk", 32'(busy), 32'h0);

    // ---- release, full contention: grant order 0,1,2,3,0
    RN = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      chk($sformatf("cont_d[%0d]", i),    32'(d),    32'(cont_d[i]));
      chk($sformatf("cont_ack[%0d]", i),  32'(ack),  32'(cont_ack[i]));
      chk($sformatf("cont_busy[%0d]", i), 32'(busy), 32'(cont_bsy[i]));
      if (cont_bsy[i]) chk($sformatf("cont_own[%0d]", i), 32'(owner), 32'(cont_own[i]));
    end

    // ---- drop all requests: finish DRIVE, gap, then idle
    req = 4'b0000;
    tick(); chk("drain_d0", 32'(d), 32'h01); chk("drain_b0", 32'(busy), 32'h1);
    tick(); chk("drain_d1", 32'(d), 32'h00); chk("drain_b1", 32'(busy), 32'h0);
    tick(); chk("drain_d2", 32'(d), 32'h00); chk("drain_a2", 32'(ack),  32'h0);

    // ---- single request from IDLE, requester 1 word 0x15 (ptr=1 here)
    din[5 +: 5] = 5'h15;
    req = 4'b0010;
    tick();
    chk("single_d",     32'(d),     32'h15);
    chk("single_ack",   32'(ack),   32'b0010);
    chk("single_owner", 32'(owner), 32'h1);
    chk("single_busy",  32'(busy),  32'h1);
    req = 4'b0000;
    tick();
    chk("single_d2",    32'(d),    32'h15);
    chk("single_ack2",  32'(ack),  32'h0);
    chk("single_busy2", 32'(busy), 32'h1);
    tick();
    chk("single_gap_d", 32'(d),    32'h00);
    chk("single_gap_b", 32'(busy), 32'h0);
    tick();
    chk("single_idle_d", 32'(d),   32'h00);
    chk("single_idle_s", 32'(dbg), 32'h0);

    // ---- round-robin wrap: grant 2 (ptr->3), then REQ=0101 -> 0 then 2
    req = 4'b0100;
    tick();
    chk("rr_g2_ack", 32'(ack), 32'b0100);
    chk("rr_g2_d",   32'(d),   32'h03);
    req = 4'b0101;
    tick();
    chk("rr_hold_ack", 32'(ack), 32'h0);
    tick();
    chk("rr_gap_d", 32'(d), 32'h00);
    tick();
    chk("rr_g0_ack",   32'(ack),   32'b0001);
    chk("rr_g0_owner", 32'(owner), 32'h0);
    chk("rr_g0_d",     32'(d),     32'h01);
    tick();
    tick();
    tick();
    chk("rr_g2b_ack",   32'(ack),   32'b0100);
    chk("rr_g2b_owner", 32'(owner), 32'h2);
    req = 4'b0000;
    tick(); tick(); tick();
    chk("rr_idle_d", 32'(d), 32'h00);

    // ---- reset in the middle of requester 3's DRIVE
    req = 4'b1000;
    tick();
    chk("mid_g3_ack", 32'(ack), 32'b1000);
    chk("mid_g3_d",   32'(d),   32'h04);
    #2;
    RN = 1'b0;
    #1;
    chk("mid_rst_d",     32'(d),     32'h00);
    chk("mid_rst_busy",  32'(busy),  32'h0);
    chk("mid_rst_ack",   32'(ack),   32'h0);
    chk("mid_rst_owner", 32'(owner), 32'h0);
    RN = 1'b1;
    req = 4'b0100;
    tick();
    chk("mid_g2_ack",   32'(ack),   32'b0100);
    chk("mid_g2_owner", 32'(owner), 32'h2);
    chk("mid_g2_d",     32'(d),     32'h03);
    // ptr must now be 3: with 0 and 3 requesting, 3 wins
    req = 4'b1001;
    tick(); tick(); tick();
    chk("mid_ptr3_ack",   32'(ack),   32'b1000);
    chk("mid_ptr3_owner", 32'(owner), 32'h3);
    req = 4'b0000;
    tick(); tick(); tick();

    // ---- GAP=0 HOLD=1 build: words alternate with no idle cycle between
    din1[0 +: 5]  = 5'h0A;
    din1[15 +: 5] = 5'h11;
    req1 = 4'b1001;
    tick(); chk("b2b_d0", 32'(d1), 32'h0A); chk("b2b_a0", 32'(ack1), 32'b0001);
    tick(); chk("b2b_d1", 32'(d1), 32'h11); chk("b2b_a1", 32'(ack1), 32'b1000);
    tick(); chk("b2b_d2", 32'(d1), 32'h0A); chk("b2b_a2", 32'(ack1), 32'b0001);
    tick(); chk("b2b_d3", 32'(d1), 32'h11); chk("b2b_a3", 32'(ack1), 32'b1000);
    chk("b2b_busy", 32'(busy1), 32'h1);
    req1 = 4'b0000;
    tick();
    tick(); chk("b2b_idle_d", 32'(d1), 32'h00); chk("b2b_idle_b", 32'(busy1), 32'h0);

    // report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
